mem_stage_oq: RTL and testbench
===============================

Name: mem_stage_oq

Overview:
Parametrised successor to the single-entry MEM stage. It holds up to DEPTH in-flight memory-stage instructions in an in-order queue, so EXE can issue a new load before the previous data_ok returns. Responses are matched in order, and load data is lane-aligned and extended at dequeue. On flush, outstanding responses are discarded through a cancel counter instead of being killed combinationally. It sits between the EXE and WB stages, replacing the single-register stage.

Parameters:
DEPTH, 2, queue entries / max outstanding requests; power of 2, at least 2
DATA_W, 32, data path width; 32 or 64 (64 enables ld.d)
PAYLOAD_W, 128, opaque pass-through bits (pc, csr fields, ecode, vaddr, ertn) carried unchanged to WB
AW, $clog2(DATA_W/8), byte-offset width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
flush  in  1  global flush from WB (exception/ertn)
in_valid  in  1  EXE has an instruction
in_ready  out  1  stage accepts (mem_allowin)
in_wait_data  in  1  instruction issued a request and expects data_ok
in_mem_op  in  4  load op encoding
in_res_from_mem  in  1  rf writes load data, else alu_result
in_rf_we  in  1  register write enable
in_rf_waddr  in  5  destination register
in_alu_result  in  DATA_W  alu result / address
in_ex  in  1  instruction carries exception or ertn
in_payload  in  PAYLOAD_W  pass-through bits
data_sram_data_ok  in  1  in-order response strobe
data_sram_rdata  in  DATA_W  response data
out_valid  out  1  head complete (mem_to_wb_valid)
out_ready  in  1  wb_allowin
out_rf_we  out  1  head rf_we
out_rf_waddr  out  5  head waddr
out_rf_wdata  out  DATA_W  aligned load data or alu_result
out_payload  out  PAYLOAD_W  head payload
fwd_we  out  DEPTH  per-entry valid & rf_we
fwd_pending  out  DEPTH  per-entry valid & res_from_mem & data not yet available
fwd_waddr  out  DEPTH*5  per-entry waddr
fwd_wdata  out  DEPTH*DATA_W  per-entry rf_wdata
mem_ex  out  1  OR over valid entries of ex
cancel_cnt  out  $clog2(2*DEPTH+1)  responses still to discard
proto_err  out  1  sticky: data_ok with no target

Behaviour:
- Reset (resetn=0 at a clk edge): all entries invalid, rd/wr pointers 0, cancel_cnt 0, proto_err 0.
- Reset outputs: out_valid=0, mem_ex=0, fwd_* all 0, in_ready=1.
- Circular queue with wrap-around pointers plus count.
  - Entry fields: valid, wait, got, raw data, op, addr_lo, res_from_mem, rf_we, waddr, alu_result, ex, payload.
- Push: in_valid & in_ready & ~flush; written at wr_ptr with got=0.
- in_ready = (count<DEPTH) | (out_valid & out_ready). Push and pop in the same cycle are allowed when full.
- data_ok attribution, priority order:
  - if cancel_cnt>0, decrement cancel_cnt and drop the data;
  - otherwise the oldest entry with wait & ~got captures rdata and sets got;
  - otherwise set proto_err and drop.
- Head is done when ~wait, or got, or (data_ok this cycle & head is the target & cancel_cnt==0). The last case is a same-cycle bypass with zero bubble.
- out_valid = head valid & head done.
- Pop: out_valid & out_ready.
- Latency:
  - entry without wait: out_valid the cycle after push if it is the head;
  - load: out_valid in the data_ok cycle.
- Flush:
  - all entries invalidated, count 0, pointers reset;
  - cancel_cnt += number of valid entries with wait & ~got, minus 1 if a data_ok is consumed by such an entry that same cycle;
  - a push in the flush cycle is dropped;
  - out_valid is still presented in the flush cycle, but WB ignores it.
- cancel_cnt bound: at most 2*DEPTH. Increment and decrement in the same cycle are netted.
- Load alignment (pure function of head op, addr_lo, data):
  - 0 ld.b and 8 ld.bu: byte lane addr_lo, sign- or zero-extended;
  - 1 ld.h and 9 ld.hu: halfword lane addr_lo[AW-1:1], sign- or zero-extended;
  - 2 ld.w: word lane, sign-extended to DATA_W;
  - 10 ld.wu (DATA_W=64 only): word lane, zero-extended;
  - 3 ld.d (DATA_W=64 only): full data;
  - any other op: 0.
- out_rf_wdata = res_from_mem ? aligned : alu_result. fwd_wdata uses the same function per entry.
- mem_ex is combinational from entry state. It is 0 in the cycle after flush.

Decomposition:
- Package mem_pkg holds:
  - MEMOP_* encoding constants;
  - entry struct typedef;
  - the count/pointer width function.
- One sub-module: load_align #(DATA_W) — combinational lane select and extension, instantiated once per entry and once for the head (or shared via fwd).

Test Plan:
- Back-to-back lw: two wait pushes, data_ok with 0x11223344 then 0x55667788 in consecutive cycles -> out_valid in each data_ok cycle, wdata in order, zero bubbles.
- Alignment: ld.b at addr_lo=3 with rdata 0x80FF0000 -> 0xFFFFFF80; ld.hu at addr_lo=2 -> 0x000080FF; op 5 -> 0.
- Full plus backpressure: DEPTH=2, out_ready=0 with both entries done -> in_ready=0; raise out_ready -> pop and push in the same cycle, count stays 2.
- Flush with 2 outstanding loads -> cancel_cnt=2, queue empty; next two data_ok dropped; a new load pushed meanwhile receives the third data_ok.
- Flush coincident with data_ok to the head -> cancel_cnt=DEPTH-1, no out_valid afterwards; flush coincident with push -> push dropped.
- Stray data_ok with the queue empty and cancel_cnt=0 -> proto_err=1 stays set; resetn=0 mid-operation -> all entries cleared, cancel_cnt=0, proto_err=0 next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the queued MEM stage: load op encodings, the
// per-entry control record and the pointer/count width helpers.
package mem_pkg;

   localparam logic [3:0] MEMOP_B  = 4'd0;
   localparam logic [3:0] MEMOP_H  = 4'd1;
   localparam logic [3:0] MEMOP_W  = 4'd2;
   localparam logic [3:0] MEMOP_D  = 4'd3;
   localparam logic [3:0] MEMOP_BU = 4'd8;
   localparam logic [3:0] MEMOP_HU = 4'd9;
   localparam logic [3:0] MEMOP_WU = 4'd10;

   // Width-independent control fields of one queue entry. The raw load data,
   // alu_result (whose low bits are addr_lo) and payload depend on module
   // parameters, so they live in parallel arrays indexed the same way.
   typedef struct packed {
      logic       valid;
      logic       wait_req;
      logic       got;
      logic [3:0] op;
      logic       res_from_mem;
      logic       rf_we;
      logic [4:0] waddr;
      logic       ex;
   } entry_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension. Purely combinational.
module load_align #(
   parameter int DATA_W = 32,
   parameter int AW     = $clog2(DATA_W / 8)
) (
   input  logic [3:0]        op,
   input  logic [AW-1:0]     addr_lo,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] result
);
   import mem_pkg::*;

   logic [AW-1:0] h_off;
   logic [AW-1:0] w_off;
   logic [7:0]    b_lane;
   logic [15:0]   h_lane;
   logic [31:0]   w_lane;

   function automatic logic [DATA_W-1:0] ext8(input logic [7:0] v, input logic sgn);
      logic [DATA_W-1:0] r;
      r      = {DATA_W{sgn & v[7]}};
      r[7:0] = v;
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] ext16(input logic [15:0] v, input logic sgn);
      logic [DATA_W-1:0] r;
      r       = {DATA_W{sgn & v[15]}};
      r[15:0] = v;
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] ext32(input logic [31:0] v, input logic sgn);
      logic [DATA_W-1:0] r;
      r       = {DATA_W{sgn & v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   // Pick the addressed lane, then extend according to the op
   always_comb begin
      h_off  = addr_lo & ~AW'(1);
      w_off  = addr_lo & ~AW'(3);
      b_lane = data[{addr_lo, 3'b000} +: 8];
      h_lane = data[{h_off, 3'b000} +: 16];
      w_lane = data[{w_off, 3'b000} +: 32];
      result = '0;
      case (op)
         MEMOP_B:  result = ext8(b_lane, 1'b1);
         MEMOP_BU: result = ext8(b_lane, 1'b0);
         MEMOP_H:  result = ext16(h_lane, 1'b1);
         MEMOP_HU: result = ext16(h_lane, 1'b0);
         MEMOP_W:  result = ext32(w_lane, 1'b1);
         MEMOP_WU: result = (DATA_W == 64) ? ext32(w_lane, 1'b0) : '0;
         MEMOP_D:  result = (DATA_W == 64) ? data : '0;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage_oq.sv
// MEM stage with an in-order queue of outstanding memory instructions.
// Responses are attributed oldest-first; flushed requests are retired by a
// cancel counter that swallows their late data_ok strobes.
module mem_stage_oq #(
   parameter int DEPTH     = 2,
   parameter int DATA_W    = 32,
   parameter int PAYLOAD_W = 128,
   parameter int AW        = $clog2(DATA_W / 8)
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_wait_data,
   input  logic [3:0]                      in_mem_op,
   input  logic                            in_res_from_mem,
   input  logic                            in_rf_we,
   input  logic [4:0]                      in_rf_waddr,
   input  logic [DATA_W-1:0]               in_alu_result,
   input  logic                            in_ex,
   input  logic [PAYLOAD_W-1:0]            in_payload,
   input  logic                            data_sram_data_ok,
   input  logic [DATA_W-1:0]               data_sram_rdata,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_rf_we,
   output logic [4:0]                      out_rf_waddr,
   output logic [DATA_W-1:0]               out_rf_wdata,
   output logic [PAYLOAD_W-1:0]            out_payload,
   output logic [DEPTH-1:0]                fwd_we,
   output logic [DEPTH-1:0]                fwd_pending,
   output logic [DEPTH*5-1:0]              fwd_waddr,
   output logic [DEPTH*DATA_W-1:0]         fwd_wdata,
   output logic                            mem_ex,
   output logic [$clog2(2*DEPTH+1)-1:0]    cancel_cnt,
   output logic                            proto_err
);
   import mem_pkg::*;

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam int KW = $clog2(2 * DEPTH + 1);

   entry_t              q      [DEPTH];
   logic [DATA_W-1:0]   q_data [DEPTH];
   logic [DATA_W-1:0]   q_alu  [DEPTH];
   logic [PAYLOAD_W-1:0] q_pay [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic          tgt_found;
   logic [PW-1:0] tgt_idx;
   logic [PW-1:0] scan_idx;
   logic          dok_cancel;
   logic          dok_capture;
   logic          dok_err;

   logic [DEPTH-1:0]  avail;
   logic [DATA_W-1:0] raw     [DEPTH];
   logic [DATA_W-1:0] aligned [DEPTH];
   logic [DATA_W-1:0] wdata   [DEPTH];

   logic          push;
   logic          pop;
   int            n_wait;
   logic [KW-1:0] cancel_nxt;

   function automatic logic [KW-1:0] sat_cancel(input int v);
      if (v < 0)
         return '0;
      if (v > 2 * DEPTH)
         return KW'(2 * DEPTH);
      return KW'(v);
   endfunction

   // Oldest valid entry still waiting for its response, scanning from the head
   always_comb begin
      tgt_found = 1'b0;
      tgt_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = rd_ptr + PW'(k);
         if (!tgt_found && q[scan_idx].valid && q[scan_idx].wait_req && !q[scan_idx].got) begin
            tgt_found = 1'b1;
            tgt_idx   = scan_idx;
         end
      end
   end

   assign dok_cancel  = data_sram_data_ok && (cancel_cnt != '0);
   assign dok_capture = data_sram_data_ok && (cancel_cnt == '0) && tgt_found;
   assign dok_err     = data_sram_data_ok && (cancel_cnt == '0) && !tgt_found;

   // Per-entry data availability, with same-cycle bypass of the arriving response
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         avail[i] = !q[i].wait_req || q[i].got || (dok_capture && (tgt_idx == PW'(i)));
         raw[i]   = (dok_capture && (tgt_idx == PW'(i))) ? data_sram_rdata : q_data[i];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_align
      load_align #(
         .DATA_W (DATA_W),
         .AW     (AW)
      ) u_align (
         .op      (q[g].op),
         .addr_lo (q_alu[g][AW-1:0]),
         .data    (raw[g]),
         .result  (aligned[g])
      );
   end

   // Per-entry writeback value and forwarding view
   always_comb begin
      mem_ex = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         wdata[i]                     = q[i].res_from_mem ? aligned[i] : q_alu[i];
         fwd_we[i]                    = q[i].valid && q[i].rf_we;
         fwd_pending[i]               = q[i].valid && q[i].res_from_mem && !avail[i];
         fwd_waddr[i*5 +: 5]          = q[i].waddr;
         fwd_wdata[i*DATA_W +: DATA_W] = wdata[i];
         mem_ex                       = mem_ex | (q[i].valid & q[i].ex);
      end
   end

   assign out_valid    = q[rd_ptr].valid && avail[rd_ptr];
   assign out_rf_we    = q[rd_ptr].rf_we;
   assign out_rf_waddr = q[rd_ptr].waddr;
   assign out_rf_wdata = wdata[rd_ptr];
   assign out_payload  = q_pay[rd_ptr];

   assign in_ready = (count < CW'(DEPTH)) || (out_valid && out_ready);
   assign push     = in_valid && in_ready && !flush;
   assign pop      = out_valid && out_ready;

   // Cancel counter update: drain one per swallowed response, add orphaned waiters on flush
   always_comb begin
      n_wait = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (q[i].valid && q[i].wait_req && !q[i].got)
            n_wait = n_wait + 1;
      end
      cancel_nxt = sat_cancel(int'(cancel_cnt) - int'(dok_cancel)
                              + (flush ? (n_wait - int'(dok_capture)) : 0));
   end

   // Queue control state: valid/got flags, pointers, count, cancel and error
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++)
            q[i].valid <= 1'b0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         cancel_cnt <= '0;
         proto_err  <= 1'b0;
      end else begin
         cancel_cnt <= cancel_nxt;
         if (dok_err)
            proto_err <= 1'b1;
         if (flush) begin
            for (int i = 0; i < DEPTH; i++)
               q[i].valid <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (dok_capture)
               q[tgt_idx].got <= 1'b1;
            if (pop) begin
               q[rd_ptr].valid <= 1'b0;
               rd_ptr          <= rd_ptr + PW'(1);
            end
            if (push) begin
               q[wr_ptr].valid        <= 1'b1;
               q[wr_ptr].wait_req     <= in_wait_data;
               q[wr_ptr].got          <= 1'b0;
               q[wr_ptr].op           <= in_mem_op;
               q[wr_ptr].res_from_mem <= in_res_from_mem;
               q[wr_ptr].rf_we        <= in_rf_we;
               q[wr_ptr].waddr        <= in_rf_waddr;
               q[wr_ptr].ex           <= in_ex;
               wr_ptr                 <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Entry data fields: captured response, alu result and payload
   always_ff @(posedge clk) begin
      if (dok_capture)
         q_data[tgt_idx] <= data_sram_rdata;
      if (push) begin
         q_alu[wr_ptr] <= in_alu_result;
         q_pay[wr_ptr] <= in_payload;
      end
   end

endmodule

// File: tb/tb_mem_stage_oq.sv
// Directed bench for mem_stage_oq (DEPTH=2, DATA_W=32).
module tb_mem_stage_oq;

   localparam int DEPTH     = 2;
   localparam int DATA_W    = 32;
   localparam int PAYLOAD_W = 16;
   localparam int KW        = $clog2(2 * DEPTH + 1);

   logic                       clk;
   logic                       resetn;
   logic                       flush;
   logic                       in_valid;
   logic                       in_ready;
   logic                       in_wait_data;
   logic [3:0]                 in_mem_op;
   logic                       in_res_from_mem;
   logic                       in_rf_we;
   logic [4:0]                 in_rf_waddr;
   logic [DATA_W-1:0]          in_alu_result;
   logic                       in_ex;
   logic [PAYLOAD_W-1:0]       in_payload;
   logic                       data_sram_data_ok;
   logic [DATA_W-1:0]          data_sram_rdata;
   logic                       out_valid;
   logic                       out_ready;
   logic                       out_rf_we;
   logic [4:0]                 out_rf_waddr;
   logic [DATA_W-1:0]          out_rf_wdata;
   logic [PAYLOAD_W-1:0]       out_payload;
   logic [DEPTH-1:0]           fwd_we;
   logic [DEPTH-1:0]           fwd_pending;
   logic [DEPTH*5-1:0]         fwd_waddr;
   logic [DEPTH*DATA_W-1:0]    fwd_wdata;
   logic                       mem_ex;
   logic [KW-1:0]              cancel_cnt;
   logic                       proto_err;

   int total = 0;
   int bad   = 0;

   mem_stage_oq #(
      .DEPTH     (DEPTH),
      .DATA_W    (DATA_W),
      .PAYLOAD_W (PAYLOAD_W)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .flush             (flush),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_wait_data      (in_wait_data),
      .in_mem_op         (in_mem_op),
      .in_res_from_mem   (in_res_from_mem),
      .in_rf_we          (in_rf_we),
      .in_rf_waddr       (in_rf_waddr),
      .in_alu_result     (in_alu_result),
      .in_ex             (in_ex),
      .in_payload        (in_payload),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_rf_we         (out_rf_we),
      .out_rf_waddr      (out_rf_waddr),
      .out_rf_wdata      (out_rf_wdata),
      .out_payload       (out_payload),
      .fwd_we            (fwd_we),
      .fwd_pending       (fwd_pending),
      .fwd_waddr         (fwd_waddr),
      .fwd_wdata         (fwd_wdata),
      .mem_ex            (mem_ex),
      .cancel_cnt        (cancel_cnt),
      .proto_err         (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush             = 1'b0;
      in_valid          = 1'b0;
      in_wait_data      = 1'b0;
      in_mem_op         = 4'd0;
      in_res_from_mem   = 1'b0;
      in_rf_we          = 1'b0;
      in_rf_waddr       = 5'd0;
      in_alu_result     = '0;
      in_ex             = 1'b0;
      in_payload        = '0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = '0;
      out_ready         = 1'b1;
   endtask

   task automatic drive(input logic w, input logic [3:0] op, input logic rfm,
                        input logic [4:0] wa, input logic [31:0] alu,
                        input logic ex, input logic [15:0] pay);
      in_valid        = 1'b1;
      in_wait_data    = w;
      in_mem_op       = op;
      in_res_from_mem = rfm;
      in_rf_we        = 1'b1;
      in_rf_waddr     = wa;
      in_alu_result   = alu;
      in_ex           = ex;
      in_payload      = pay;
   endtask

   initial begin
      resetn = 1'b0;
      idle();
      tick();
      tick();
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_fwd_we", fwd_we, 0);
      chk("rst_fwd_pending", fwd_pending, 0);
      chk("rst_mem_ex", mem_ex, 0);
      chk("rst_cancel", cancel_cnt, 0);
      chk("rst_proto", proto_err, 0);
      resetn = 1'b1;
      tick();

      // back-to-back word loads, responses in consecutive cycles
      drive(1, 4'd2, 1, 5'd5, 32'h1000, 0, 16'hA1);
      #2; chk("b2b_ready0", in_ready, 1);
      tick();
      drive(1, 4'd2, 1, 5'd6, 32'h1004, 0, 16'hB2);
      #2; chk("b2b_wait_ov", out_valid, 0);
      chk("b2b_pend_a", fwd_pending, 2'b01);
      tick();
      idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11223344;
      #2; chk("b2b_ov_a", out_valid, 1);
      chk("b2b_wdata_a", out_rf_wdata, 32'h11223344);
      chk("b2b_waddr_a", out_rf_waddr, 5);
      chk("b2b_pay_a", out_payload, 16'hA1);
      chk("b2b_pend_b", fwd_pending, 2'b10);
      tick();
      data_sram_rdata = 32'h55667788;
      #2; chk("b2b_ov_b", out_valid, 1);
      chk("b2b_wdata_b", out_rf_wdata, 32'h55667788);
      chk("b2b_waddr_b", out_rf_waddr, 6);
      chk("b2b_pay_b", out_payload, 16'hB2);
      tick();
      idle();
      #2; chk("b2b_empty_ov", out_valid, 0);
      chk("b2b_empty_we", fwd_we, 0);
      tick();

      // alignment: ld.b @3, ld.hu @2, unknown op 5, plain alu result
      drive(1, 4'd0, 1, 5'd7, 32'h3, 0, 16'h3);
      tick();
      idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF0000;
      #2; chk("al_ldb_ov", out_valid, 1);
      chk("al_ldb", out_rf_wdata, 32'hFFFFFF80);
      tick();
      idle(); drive(1, 4'd9, 1, 5'd7, 32'h2, 0, 16'h4);
      tick();
      idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF0000;
      #2; chk("al_ldhu", out_rf_wdata, 32'h000080FF);
      tick();
      idle(); drive(1, 4'd5, 1, 5'd7, 32'h0, 0, 16'h5);
      tick();
      idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12345678;
      #2; chk("al_op5_ov", out_valid, 1);
      chk("al_op5", out_rf_wdata, 32'h0);
      tick();
      idle(); drive(0, 4'd2, 0, 5'd11, 32'hDEADBEEF, 0, 16'h55);
      #2; chk("al_alu_pre_ov", out_valid, 0);
      tick();
      idle();
      #2; chk("al_alu_ov", out_valid, 1);
      chk("al_alu", out_rf_wdata, 32'hDEADBEEF);
      chk("al_alu_fwd_we", fwd_we, 2'b10);
      tick();

      // full queue with backpressure, then simultaneous pop and push
      idle(); out_ready = 1'b0;
      drive(0, 4'd2, 0, 5'd1, 32'h111, 0, 16'h1);
      tick();
      drive(0, 4'd2, 0, 5'd2, 32'h222, 0, 16'h2);
      #2; chk("full_ready_1", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #2; chk("full_ready_0", in_ready, 0);
      chk("full_ov", out_valid, 1);
      chk("full_wdata", out_rf_wdata, 32'h111);
      chk("full_fwd_we", fwd_we, 2'b11);
      chk("full_fwd_waddr", fwd_waddr, 10'b00010_00001);
      chk("full_fwd_wdata", fwd_wdata, 64'h00000222_00000111);
      tick();
      out_ready = 1'b1;
      drive(0, 4'd2, 0, 5'd3, 32'h333, 0, 16'h3);
      #2; chk("pp_ready", in_ready, 1);
      chk("pp_wdata", out_rf_wdata, 32'h111);
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      #2; chk("pp_still_full", in_ready, 0);
      chk("pp_head", out_rf_wdata, 32'h222);
      chk("pp_fwd_waddr", fwd_waddr, 10'b00010_00011);
      tick();
      out_ready = 1'b1;
      #2; chk("drain_y", out_rf_wdata, 32'h222);
      tick();
      #2; chk("drain_z", out_rf_wdata, 32'h333);
      tick();
      #2; chk("drain_ov", out_valid, 0);
      chk("drain_ready", in_ready, 1);
      tick();

      // flush with two outstanding loads
      idle(); drive(1, 4'd2, 1, 5'd8, 32'h40, 0, 16'h8);
      tick();
      drive(1, 4'd2, 1, 5'd9, 32'h44, 0, 16'h9);
      tick();
      idle(); flush = 1'b1;
      #2; chk("fl_ov", out_valid, 0);
      tick();
      idle();
      #2; chk("fl_cancel2", cancel_cnt, 2);
      chk("fl_empty_ov", out_valid, 0);
      chk("fl_empty_we", fwd_we, 0);
      chk("fl_ready", in_ready, 1);
      tick();
      drive(1, 4'd2, 1, 5'd10, 32'h2000, 0, 16'hA);
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA;
      #2; chk("fl_drop1_ov", out_valid, 0);
      tick();
      idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBBBB;
      #2; chk("fl_cancel1", cancel_cnt, 1);
      chk("fl_drop2_ov", out_valid, 0);
      chk("fl_l3_pend", fwd_pending, 2'b01);
      tick();
      data_sram_rdata = 32'hCCCC;
      #2; chk("fl_cancel0", cancel_cnt, 0);
      chk("fl_l3_ov", out_valid, 1);
      chk("fl_l3_wdata", out_rf_wdata, 32'hCCCC);
      chk("fl_l3_waddr", out_rf_waddr, 10);
      tick();
      idle();
      #2; chk("fl_proto", proto_err, 0);
      chk("fl_after_ov", out_valid, 0);
      tick();

      // flush coincident with the head's response
      drive(1, 4'd2, 1, 5'd12, 32'h60, 0, 16'hC);
      tick();
      drive(1, 4'd2, 1, 5'd13, 32'h64, 0, 16'hD);
      tick();
      idle(); flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1;
      #2; chk("fd_ov_in_flush", out_valid, 1);
      tick();
      idle();
      #2; chk("fd_cancel", cancel_cnt, DEPTH - 1);
      chk("fd_ov", out_valid, 0);
      chk("fd_we", fwd_we, 0);
      tick();
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h9;
      #2; chk("fd_drop_ov", out_valid, 0);
      tick();
      idle();
      #2; chk("fd_cancel0", cancel_cnt, 0);
      chk("fd_proto", proto_err, 0);
      tick();

      // mem_ex from a held entry, then flush coincident with a push
      out_ready = 1'b0;
      drive(0, 4'd2, 0, 5'd14, 32'h77, 1, 16'hE);
      tick();
      in_valid = 1'b0;
      #2; chk("ex_set", mem_ex, 1);
      drive(0, 4'd2, 0, 5'd15, 32'h88, 0, 16'hF);
      flush = 1'b1;
      tick();
      idle();
      #2; chk("fp_mem_ex", mem_ex, 0);
      chk("fp_ov", out_valid, 0);
      chk("fp_we", fwd_we, 0);
      chk("fp_ready", in_ready, 1);
      tick();

      // stray response with nothing outstanding
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD;
      tick();
      idle();
      #2; chk("stray_proto", proto_err, 1);
      tick();
      #2; chk("stray_sticky", proto_err, 1);

      // reset in the middle of activity
      drive(1, 4'd2, 1, 5'd16, 32'h50, 0, 16'h0);
      tick();
      drive(1, 4'd2, 1, 5'd17, 32'h54, 0, 16'h0);
      tick();
      idle(); flush = 1'b1;
      tick();
      idle(); drive(1, 4'd2, 1, 5'd18, 32'h58, 0, 16'h0);
      tick();
      idle();
      #2; chk("mr_pre_cancel", cancel_cnt, 2);
      chk("mr_pre_pend", fwd_pending, 2'b01);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      #2; chk("mr_cancel", cancel_cnt, 0);
      chk("mr_proto", proto_err, 0);
      chk("mr_ov", out_valid, 0);
      chk("mr_we", fwd_we, 0);
      chk("mr_pend", fwd_pending, 0);
      chk("mr_mem_ex", mem_ex, 0);
      chk("mr_ready", in_ready, 1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
